// File: rtl/imm_gen_pipe_if.sv
// Bundle handshake bus for the immediate generator: fetch side in, execute side out.
// Latency: none (wires only).
// Backpressure: in_ready_o / out_ready_i carry the valid-ready flow control.
interface imm_gen_pipe_if #(
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 2
);
    logic                          flush_i;
    logic                          in_valid_i;
    logic                          in_ready_o;
    logic [LANES*DATA_WIDTH-1:0]   instr_i;
    logic [LANES*3-1:0]            imm_src_i;
    logic                          out_valid_o;
    logic                          out_ready_i;
    logic [LANES*DATA_WIDTH-1:0]   imm_o;
    logic [LANES-1:0]              imm_err_o;

    // Seen from the immediate generator itself.
    modport slave (
        input  flush_i, in_valid_i, instr_i, imm_src_i, out_ready_i,
        output in_ready_o, out_valid_o, imm_o, imm_err_o
    );

    // Seen from the surrounding decode logic (or a bench).
    modport master (
        output flush_i, in_valid_i, instr_i, imm_src_i, out_ready_i,
        input  in_ready_o, out_valid_o, imm_o, imm_err_o
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Multi-lane registered immediate generator; IMM_ZICSR_EN enables the Z (CSR uimm) format.
// Latency: 1 cycle from input transfer to out_valid_o (main register plus one skid entry).
// Backpressure: in_ready_o is a registered !skid_valid; a stalled consumer fills the skid, never drops.
module imm_gen_pipe #(
    parameter int DATA_WIDTH = 32,   // only 32 is supported
    parameter int LANES      = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    imm_gen_pipe_if.slave    bus
);

    localparam int BW = LANES * DATA_WIDTH;

    // Decode one lane. Opcode bits [6:0] play no part in any immediate format.
    // Returns {err, imm}.
    function automatic logic [32:0] decode_lane(input logic [31:7] i, input logic [2:0] src);
        logic [32:0] r;
        r = {1'b1, 32'b0};
        case (src)
            3'b000: r = {1'b0, {20{i[31]}}, i[31:20]};
            3'b001: r = {1'b0, {20{i[31]}}, i[31:25], i[11:7]};
            3'b010: r = {1'b0, {19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'b011: r = {1'b0, i[31:12], 12'b0};
            3'b100: r = {1'b0, {11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
`ifdef IMM_ZICSR_EN
            3'b101: r = {1'b0, 27'b0, i[19:15]};
`else
            3'b101: r = {1'b1, 32'b0};
`endif
            default: r = {1'b1, 32'b0};
        endcase
        return r;
    endfunction

    logic [BW-1:0]          dec_imm;
    logic [LANES-1:0]       dec_err;
    logic [LANES*7-1:0]     opcode_unused;

    logic                   main_vld;
    logic [BW-1:0]          main_imm;
    logic [LANES-1:0]       main_err;
    logic                   skid_vld;
    logic [BW-1:0]          skid_imm;
    logic [LANES-1:0]       skid_err;

    logic                   in_xfer;
    logic                   out_xfer;

    // Lanes are decoded independently; the bundle then moves as one unit.
    always_comb begin
        dec_imm       = '0;
        dec_err       = '0;
        opcode_unused = '0;
        for (int k = 0; k < LANES; k++) begin
            {dec_err[k], dec_imm[k*DATA_WIDTH +: DATA_WIDTH]} =
                decode_lane(bus.instr_i[k*DATA_WIDTH+7 +: 25], bus.imm_src_i[k*3 +: 3]);
            opcode_unused[k*7 +: 7] = bus.instr_i[k*DATA_WIDTH +: 7];
        end
    end

    assign in_xfer  = bus.in_valid_i & ~skid_vld;
    assign out_xfer = main_vld & bus.out_ready_i;

    // Main/skid pair: skid drains into main before new input so bundle order is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_vld <= 1'b0;
            main_imm <= '0;
            main_err <= '0;
            skid_vld <= 1'b0;
            skid_imm <= '0;
            skid_err <= '0;
        end else if (bus.flush_i) begin
            // Redirect: everything buffered and anything offered now is stale.
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else if (!main_vld || out_xfer) begin
            if (skid_vld) begin
                main_imm <= skid_imm;
                main_err <= skid_err;
                main_vld <= 1'b1;
                skid_vld <= 1'b0;
            end else if (in_xfer) begin
                main_imm <= dec_imm;
                main_err <= dec_err;
                main_vld <= 1'b1;
            end else begin
                main_vld <= 1'b0;
            end
        end else if (in_xfer) begin
            // Main is stalled; park the new bundle until it drains.
            skid_imm <= dec_imm;
            skid_err <= dec_err;
            skid_vld <= 1'b1;
        end
    end

    assign bus.in_ready_o  = ~skid_vld;
    assign bus.out_valid_o = main_vld;
    assign bus.imm_o       = main_imm;
    assign bus.imm_err_o   = main_err;

endmodule
